multi_key_debouncer: RTL and testbench

//  Debounces NUM_KEYS independent push-button/switch inputs in a single clock domain.

---
 rtl/multi_key_debouncer.sv | 147 ++++++++++++++
 tb/tb_multi_key_debouncer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multi_key_debouncer.sv
// multi_key_debouncer
//   Debounces NUM_KEYS independent key/switch inputs in one clock domain.
//   Each channel has a 2-FF synchroniser, polarity normalisation and a
//   saturating stability counter. Once the synchronised level has differed
//   from the debounced level for 2^CNT_WIDTH consecutive cycles, the
//   debounced level toggles and a one-cycle pressed/released strobe fires.
//
//   Optional feature (macro KEY_AUTOREPEAT_EN): per-channel auto-repeat.
//   The first repeat_pulse comes REPEAT_DELAY cycles after the press strobe.
//   Later pulses follow every REPEAT_PERIOD cycles while the key stays held.
//   Without the macro, repeat_pulse is tied to 0 and no repeat counters exist.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   keys_in       raw asynchronous key inputs (NUM_KEYS)
//   key_state     debounced level, 1 = pressed (registered)
//   pressed       1-cycle strobe on debounced 0->1 (registered)
//   released      1-cycle strobe on debounced 1->0 (registered)
//   repeat_pulse  1-cycle auto-repeat strobe (registered, 0 without macro)
//   any_event     OR of all pressed|released bits, same cycle as the strobes
module multi_key_debouncer #(
    parameter int unsigned NUM_KEYS      = 4,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned ACTIVE_LOW    = 1,
    parameter int unsigned REP_CNT_WIDTH = 20,
    parameter int unsigned REPEAT_DELAY  = 500000,
    parameter int unsigned REPEAT_PERIOD = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] released,
    output logic [NUM_KEYS-1:0] repeat_pulse,
    output logic                any_event
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Elaboration-time sanity check of the parameter set
    if ((NUM_KEYS < 1) || (CNT_WIDTH < 1) || (REP_CNT_WIDTH < 1) ||
        (REPEAT_PERIOD < 1) || (REPEAT_PERIOD > REPEAT_DELAY) ||
        ((REP_CNT_WIDTH < 32) && ((REPEAT_DELAY >> REP_CNT_WIDTH) != 0)))
    begin : g_param_check
        $error("multi_key_debouncer: illegal parameter set");
    end

    logic [NUM_KEYS-1:0]                norm;
    logic [NUM_KEYS-1:0]                sync0;
    logic [NUM_KEYS-1:0]                sync1;
    logic [NUM_KEYS-1:0][CNT_WIDTH-1:0] cnt_q;
    logic [NUM_KEYS-1:0][CNT_WIDTH-1:0] cnt_d;
    logic [NUM_KEYS-1:0]                state_d;
    logic [NUM_KEYS-1:0]                pressed_d;
    logic [NUM_KEYS-1:0]                released_d;
    logic [NUM_KEYS-1:0]                toggle_d;
    logic                               any_event_d;

    // Polarity normalisation: after this, 1 always means pressed
    assign norm = (ACTIVE_LOW != 0) ? ~keys_in : keys_in;

    // Stability counter and toggle decision per channel
    always_comb begin
        cnt_d       = '0;
        state_d     = key_state;
        pressed_d   = '0;
        released_d  = '0;
        toggle_d    = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (sync1[k] != key_state[k]) begin
                // Saturation point is the toggle point, so the counter never wraps
                if (cnt_q[k] == CNT_MAX) begin
                    toggle_d[k]   = 1'b1;
                    state_d[k]    = ~key_state[k];
                    pressed_d[k]  = ~key_state[k];
                    released_d[k] = key_state[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
                end
            end
        end
        any_event_d = |(pressed_d | released_d);
    end

    // Synchroniser, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0     <= '0;
            sync1     <= '0;
            cnt_q     <= '0;
            key_state <= '0;
            pressed   <= '0;
            released  <= '0;
            any_event <= 1'b0;
        end else begin
            sync0     <= norm;
            sync1     <= sync0;
            cnt_q     <= cnt_d;
            key_state <= state_d;
            pressed   <= pressed_d;
            released  <= released_d;
            any_event <= any_event_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    // Firing one count early lets the pulse register on the REPEAT_DELAY-th edge after press
    localparam logic [REP_CNT_WIDTH-1:0] REP_FIRE   = REP_CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [REP_CNT_WIDTH-1:0] REP_RELOAD = REP_CNT_WIDTH'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [NUM_KEYS-1:0][REP_CNT_WIDTH-1:0] rep_q;
    logic [NUM_KEYS-1:0][REP_CNT_WIDTH-1:0] rep_d;
    logic [NUM_KEYS-1:0]                    repeat_d;

    // Repeat counter runs only while the debounced key is held and not toggling
    always_comb begin
        rep_d    = '0;
        repeat_d = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (key_state[k] && !toggle_d[k]) begin
                if (rep_q[k] == REP_FIRE) begin
                    repeat_d[k] = 1'b1;
                    rep_d[k]    = REP_RELOAD;
                end else begin
                    rep_d[k] = rep_q[k] + REP_CNT_WIDTH'(1);
                end
            end
        end
    end

    // Repeat counter and strobe registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_q        <= '0;
            repeat_pulse <= '0;
        end else begin
            rep_q        <= rep_d;
            repeat_pulse <= repeat_d;
        end
    end
`else
    assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Scoreboard bench for multi_key_debouncer (NUM_KEYS=4, CNT_WIDTH=4, ACTIVE_LOW=1,
// REPEAT_DELAY=40, REPEAT_PERIOD=10). Stimulus pushes expected output events;
// a negedge monitor pops and compares whenever the DUT shows a strobe.
module tb_multi_key_debouncer;

    localparam int unsigned NK  = 4;
    localparam int unsigned WIN = 18;  // first sampling edge = 1, update at edge 2^4+2
`ifdef KEY_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    typedef struct {
        int unsigned   cyc;
        logic [NK-1:0] ks;
        logic [NK-1:0] pr;
        logic [NK-1:0] rl;
        logic [NK-1:0] rp;
        logic          ae;
    } ev_t;

    logic          clk;
    logic          reset;
    logic [NK-1:0] keys_in;
    logic [NK-1:0] key_state;
    logic [NK-1:0] pressed;
    logic [NK-1:0] released;
    logic [NK-1:0] repeat_pulse;
    logic          any_event;

    int unsigned cyc;
    int unsigned n_cmp;
    int unsigned n_bad;
    ev_t         exp_q[$];

    multi_key_debouncer #(
        .NUM_KEYS     (NK),
        .CNT_WIDTH    (4),
        .ACTIVE_LOW   (1),
        .REP_CNT_WIDTH(8),
        .REPEAT_DELAY (40),
        .REPEAT_PERIOD(10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .keys_in     (keys_in),
        .key_state   (key_state),
        .pressed     (pressed),
        .released    (released),
        .repeat_pulse(repeat_pulse),
        .any_event   (any_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic void push(input int unsigned c, input logic [NK-1:0] ks,
                                 input logic [NK-1:0] pr, input logic [NK-1:0] rl,
                                 input logic [NK-1:0] rp, input logic ae);
        ev_t e;
        e.cyc = c; e.ks = ks; e.pr = pr; e.rl = rl; e.rp = rp; e.ae = ae;
        exp_q.push_back(e);
    endfunction

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: pops an expected record whenever the DUT presents any strobe
    always @(negedge clk) begin
        ev_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("missed_event_cycle", 32'(cyc), 32'(e.cyc));
        end
        if (any_event || (|pressed) || (|released) || (|repeat_pulse)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: cycle %0d pressed=%b released=%b repeat=%b any=%b, required none",
                         cyc, pressed, released, repeat_pulse, any_event);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle",  32'(cyc),          32'(e.cyc));
                check("key_state",    32'(key_state),    32'(e.ks));
                check("pressed",      32'(pressed),      32'(e.pr));
                check("released",     32'(released),     32'(e.rl));
                check("repeat_pulse", 32'(repeat_pulse), 32'(REP_EN ? e.rp : 4'b0000));
                check("any_event",    32'(any_event),    32'(e.ae));
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_key_state"}, 32'(key_state),    32'(0));
        check({tag, "_pressed"},   32'(pressed),      32'(0));
        check({tag, "_released"},  32'(released),     32'(0));
        check({tag, "_repeat"},    32'(repeat_pulse), 32'(0));
        check({tag, "_any_event"}, 32'(any_event),    32'(0));
    endtask

    initial begin
        int unsigned t;
        int unsigned p;
        int unsigned r;
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        keys_in = 4'b1111;

        // 1: reset with all keys released, then 50 idle cycles
        repeat (3) @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check("idle_key_state", 32'(key_state), 32'(0));

        // 2: press key 0, hold for repeats, release
        keys_in[0] = 1'b0;
        t = cyc;
        p = t + WIN;
        r = p + 62 + WIN;
        push(p, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
        if (REP_EN) begin
            for (int unsigned c = p + 40; c < r; c += 10)
                push(c, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0);
        end
        push(r, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1);
        wait_cyc(p + 62);
        keys_in[0] = 1'b1;
        wait_cyc(r + 5);
        check("after_key0_state", 32'(key_state), 32'(0));

        // 3: 10-cycle glitch on key 1 is dropped
        keys_in[1] = 1'b0;
        t = cyc;
        wait_cyc(t + 10);
        keys_in[1] = 1'b1;
        wait_cyc(t + 40);
        check("glitch_key_state", 32'(key_state), 32'(0));
        check("glitch_pending",   32'(exp_q.size()), 32'(0));

        // 4: keys 3 and 2 pressed and released together
        keys_in[3:2] = 2'b00;
        t = cyc;
        p = t + WIN;
        push(p, 4'b1100, 4'b1100, 4'b0000, 4'b0000, 1'b1);
        wait_cyc(p + 2);
        keys_in[3:2] = 2'b11;
        r = p + 2 + WIN;
        push(r, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 1'b1);
        wait_cyc(r + 5);

        // 5: reset at edge 10 of a press window discards the partial count
        keys_in[0] = 1'b0;
        t = cyc;
        wait_cyc(t + 10);
        reset = 1'b1;
        wait_cyc(t + 12);
        check_quiet("midreset");
        reset = 1'b0;
        p = t + 12 + WIN;
        push(p, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
        wait_cyc(p + 2);
        keys_in[0] = 1'b1;
        r = p + 2 + WIN;
        push(r, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b1);

        // Drain with a bounded wait
        for (int unsigned i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("queue_drained",   32'(exp_q.size()), 32'(0));
        check("final_key_state", 32'(key_state),    32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
